// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue front end: widths, instruction field
// positions, unit codes, the decoded bundle and the decoder helpers.
package issue_unit_pkg;

    localparam int REG_SIZE  = 6;
    localparam int WORD_SIZE = 32;
    localparam int IMM_W     = 16;

    // Instruction field bit positions
    localparam int OP_HI      = 31;
    localparam int OP_LO      = 29;
    localparam int HASIMM_BIT = 28;
    localparam int R1_HI      = 27;
    localparam int R1_LO      = 22;
    localparam int R2_HI      = 21;
    localparam int R2_LO      = 16;
    localparam int R3_HI      = 15;
    localparam int R3_LO      = 10;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;

    typedef enum logic [2:0] {
        UNIT_LW  = 3'b000,
        UNIT_SW  = 3'b001,
        UNIT_ADD = 3'b010,
        UNIT_MUL = 3'b011,
        UNIT_MV  = 3'b100
    } unit_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        unit_t                unit;
        logic                 hasimm;
        logic [REG_SIZE-1:0]  reg1;
        logic [REG_SIZE-1:0]  reg2;
        logic [REG_SIZE-1:0]  reg3;
        logic [WORD_SIZE-1:0] imm;
    } bundle_t;

    // Opcodes above the mv encoding have no execution unit.
    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Splits a raw word into the RS bundle; unused reg3/imm are zeroed.
    function automatic bundle_t decode(input logic [WORD_SIZE-1:0] w);
        bundle_t b;
        case (w[OP_HI:OP_LO])
            3'b000:  b.unit = UNIT_LW;
            3'b001:  b.unit = UNIT_SW;
            3'b010:  b.unit = UNIT_ADD;
            3'b011:  b.unit = UNIT_MUL;
            3'b100:  b.unit = UNIT_MV;
            default: b.unit = UNIT_LW;
        endcase
        b.hasimm = w[HASIMM_BIT];
        b.reg1   = w[R1_HI:R1_LO];
        b.reg2   = w[R2_HI:R2_LO];
        if (w[HASIMM_BIT]) begin
            b.reg3 = {REG_SIZE{1'b0}};
            b.imm  = {{(WORD_SIZE-IMM_W){w[IMM_HI]}}, w[IMM_HI:IMM_LO]};
        end else begin
            b.reg3 = w[R3_HI:R3_LO];
            b.imm  = {WORD_SIZE{1'b0}};
        end
        return b;
    endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Fetch-side and RS-side handshake signals of the issue unit.
interface issue_unit_if;

    logic                                     inst_valid;
    logic [issue_unit_pkg::WORD_SIZE-1:0]     inst_data;
    logic                                     inst_ready;
    logic                                     flush;
    logic [2:0]                               unit;
    logic [issue_unit_pkg::REG_SIZE-1:0]      reg1;
    logic [issue_unit_pkg::REG_SIZE-1:0]      reg2;
    logic [issue_unit_pkg::REG_SIZE-1:0]      reg3;
    logic                                     hasimm;
    logic [issue_unit_pkg::WORD_SIZE-1:0]     imm;
    logic                                     enable;
    logic                                     accept;

    // Environment side: fetch stage plus reservation station
    modport master (
        output inst_valid, inst_data, flush, accept,
        input  inst_ready, unit, reg1, reg2, reg3, hasimm, imm, enable
    );

    // Issue unit side
    modport slave (
        input  inst_valid, inst_data, flush, accept,
        output inst_ready, unit, reg1, reg2, reg3, hasimm, imm, enable
    );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO with flush. Exposes the head and the entry behind it so
// a consumer can preload the next item while the head is being popped.
module issue_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_next,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] nxt_ptr_s;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign nxt_ptr_s = rd_ptr_r + PTR_W'(1);
    assign rd_data   = mem_r[rd_ptr_r];
    assign rd_next   = mem_r[nxt_ptr_s];

    // Pointer and occupancy bookkeeping; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= nxt_ptr_s;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Issue front end: decodes fetched words, buffers the decoded bundles and
// presents them in order to the reservation station, retrying while full.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    issue_unit_if.slave      bus,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t         state_r;
    state_t         state_s;
    bundle_t        payload_r;
    bundle_t        payload_s;
    bundle_t        dec_s;
    bundle_t        head_s;
    bundle_t        next_s;
    logic           full_s;
    logic           empty_s;
    logic [PTR_W:0] count_s;
    logic           take_s;
    logic           legal_s;
    logic           push_s;
    logic           pop_s;
    logic           illegal_r;
    logic [CNT_W-1:0] issued_r;
    logic [CNT_W-1:0] stall_r;

    assign dec_s   = decode(bus.inst_data);
    assign legal_s = op_legal(bus.inst_data[OP_HI:OP_LO]);
    // Illegal words still complete the handshake; they are simply not stored
    assign take_s  = bus.inst_valid & ~full_s;
    assign push_s  = take_s & legal_s & ~bus.flush;
    assign pop_s   = (state_r == ST_ISSUE) & bus.accept;

    assign bus.inst_ready = ~full_s;
    assign bus.enable     = (state_r == ST_ISSUE);
    assign bus.unit       = payload_r.unit;
    assign bus.reg1       = payload_r.reg1;
    assign bus.reg2       = payload_r.reg2;
    assign bus.reg3       = payload_r.reg3;
    assign bus.hasimm     = payload_r.hasimm;
    assign bus.imm        = payload_r.imm;
    assign illegal        = illegal_r;
    assign issued_cnt     = issued_r;
    assign stall_cnt      = stall_r;

    issue_fifo #(
        .WIDTH ($bits(bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (dec_s),
        .rd_data (head_s),
        .rd_next (next_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Next state and next payload; the payload always mirrors the FIFO head
    always_comb begin
        state_s   = state_r;
        payload_s = payload_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.flush) begin
                    state_s = ST_IDLE;
                end else if (!empty_s) begin
                    state_s   = ST_ISSUE;
                    payload_s = head_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.flush) begin
                    state_s = ST_IDLE;
                end else if (bus.accept) begin
                    // Head leaves; present whatever becomes the new head
                    if (count_s > (PTR_W+1)'(1)) begin
                        payload_s = next_s;
                    end else if (push_s) begin
                        payload_s = dec_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            payload_r <= '0;
        end else begin
            state_r   <= state_s;
            payload_r <= payload_s;
        end
    end

    // One-cycle pulse for a dropped undefined-opcode word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_r <= 1'b0;
        else     illegal_r <= take_s & ~legal_s;
    end

    // Saturating issue and stall statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_r <= {CNT_W{1'b0}};
            stall_r  <= {CNT_W{1'b0}};
        end else begin
            if (pop_s && issued_r != CNT_MAX) issued_r <= issued_r + CNT_W'(1);
            if ((state_r == ST_ISSUE) && !bus.accept && stall_r != CNT_MAX)
                stall_r <= stall_r + CNT_W'(1);
        end
    end

endmodule
